// File: rtl/arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: sizes, FSM
// encoding and the rotating-priority search.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Lowest-index requester at or above ptr (mod NUM_REQ), skipping masked clients.
  // Callers only use the result when at least one unmasked request is present.
  function automatic logic [ID_W-1:0] next_winner(input logic [NUM_REQ-1:0] req,
                                                  input logic [ID_W-1:0]    ptr,
                                                  input logic [NUM_REQ-1:0] excl_mask);
    logic [ID_W-1:0] idx;
    logic            found;
    next_winner = ptr;
    found       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx] && !excl_mask[idx]) begin
        next_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/Decoder_2_4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module Decoder_2_4 (
  input  logic [1:0] inp,
  input  logic       enable,
  output logic [3:0] out
);

  always_comb begin
    out = '0;
    if (enable) out[inp] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter_4.sv
// 4-requester round-robin arbiter with one-hot decoded grant.
// Optional hold limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module rr_grant_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_W-1:0]     gnt_id,
  output logic                gnt_valid,
  output logic                timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD);

  arb_state_e          state;
  logic [ID_W-1:0]     owner;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  excl_mask;
  logic [ID_W-1:0]     winner;
  logic                any_other;
  logic                owner_req;
  logic                limit_hit;

  // While granted, the releasing owner is excluded from the re-arbitration.
  always_comb begin
    excl_mask = '0;
    if (state == ST_GRANT) excl_mask[owner] = 1'b1;
  end

  assign winner    = next_winner(req, ptr, excl_mask);
  assign any_other = |(req & ~excl_mask);
  assign owner_req = req[owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any_other) begin
            state <= ST_GRANT;
            owner <= winner;
            ptr   <= winner + ID_W'(1);
          end
        end
        ST_GRANT: begin
          if (owner_req) begin
            if (limit_hit) state <= ST_IDLE;
          end else if (any_other) begin
            owner <= winner;
            ptr   <= winner + ID_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_reg;

  assign limit_hit = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Counter only runs while the same owner keeps its request; anything else restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= (state == ST_GRANT) && owner_req && limit_hit;
      if ((state == ST_GRANT) && owner_req && !limit_hit) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_cfg;

  assign limit_hit  = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = (MAX_HOLD > CNT_W);
`endif

  assign gnt_id    = owner;
  assign gnt_valid = (state == ST_GRANT);

  Decoder_2_4 u_gnt_dec (
    .inp    (gnt_id),
    .enable (gnt_valid),
    .out    (gnt)
  );

endmodule
